// File: rtl/pht_port_sched.sv
// Single-port scheduler for the gshare pattern-history/target table.
// Clears the table after reset, then arbitrates lookups against buffered updates.
module pht_port_sched #(
    parameter int HISTORY_SIZE = 4,
    parameter int UBUF_DEPTH = 4,
    parameter int STARVE_LIMIT = 8,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic lookup_valid_i,
    input  logic [HISTORY_SIZE-1:0] lookup_idx_i,
    output logic lookup_ready_o,
    output logic pred_valid_o,
    output logic pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic upd_valid_i,
    input  logic [HISTORY_SIZE-1:0] upd_idx_i,
    input  logic upd_taken_i,
    input  logic [31:0] upd_target_i,
    output logic upd_ready_o,
    output logic clear_busy_o,
    output logic tbl_en_o,
    output logic tbl_we_o,
    output logic [HISTORY_SIZE-1:0] tbl_addr_o,
    output logic [33:0] tbl_wdata_o,
    input  logic [33:0] tbl_rdata_i
);

    localparam int PW = (UBUF_DEPTH > 1) ? $clog2(UBUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(UBUF_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [HISTORY_SIZE-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        UPD_WR
    } state_t;

    state_t state, next_state;

    logic [HISTORY_SIZE-1:0] clear_idx;
    logic [SW-1:0] starve_cnt;

    logic [HISTORY_SIZE-1:0] fifo_idx [UBUF_DEPTH];
    logic fifo_taken [UBUF_DEPTH];
    logic [31:0] fifo_target [UBUF_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [HISTORY_SIZE-1:0] held_idx;
    logic held_taken;
    logic [31:0] held_target;

    logic full, empty, force_upd, push, pop, grant_lk;
    logic en, we;
    logic [HISTORY_SIZE-1:0] addr;
    logic [33:0] wdata;
    logic [1:0] ctr, ctr_next;
    logic pred_valid_q;

    assign full = (count == FULL_CNT);
    assign empty = (count == '0);
    assign force_upd = full || (starve_cnt == STARVE_MAX && !empty);
    assign push = upd_valid_i && !full;

    assign ctr = tbl_rdata_i[33:32];

    always_comb begin
        ctr_next = ctr;
        if (held_taken) begin
            if (ctr != 2'b11) ctr_next = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) ctr_next = ctr - 2'b01;
        end
    end

    always_comb begin
        next_state = state;
        en = 1'b0;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        pop = 1'b0;
        grant_lk = 1'b0;
        unique case (state)
            CLEAR: begin
                en = 1'b1;
                we = 1'b1;
                addr = clear_idx;
                wdata = {INIT_STATE, 32'h0};
                if (clear_idx == LAST_IDX) next_state = IDLE;
            end
            IDLE: begin
                if (force_upd) begin
                    pop = 1'b1;
                end else if (lookup_valid_i) begin
                    grant_lk = 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                end
                if (pop) begin
                    en = 1'b1;
                    addr = fifo_idx[rd_ptr];
                    next_state = UPD_WR;
                end else if (grant_lk) begin
                    en = 1'b1;
                    addr = lookup_idx_i;
                end
            end
            UPD_WR: begin
                en = 1'b1;
                we = 1'b1;
                addr = held_idx;
                // Not-taken keeps the stored target; only taken refreshes it.
                wdata = {ctr_next,
                         held_taken ? held_target : tbl_rdata_i[31:0]};
                next_state = IDLE;
            end
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= CLEAR;
            clear_idx <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) clear_idx <= clear_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < UBUF_DEPTH; i++) begin
                fifo_idx[i] <= '0;
                fifo_taken[i] <= 1'b0;
                fifo_target[i] <= '0;
            end
        end else if (push) begin
            fifo_idx[wr_ptr] <= upd_idx_i;
            fifo_taken[wr_ptr] <= upd_taken_i;
            fifo_target[wr_ptr] <= upd_target_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            held_idx <= '0;
            held_taken <= 1'b0;
            held_target <= '0;
        end else if (pop) begin
            held_idx <= fifo_idx[rd_ptr];
            held_taken <= fifo_taken[rd_ptr];
            held_target <= fifo_target[rd_ptr];
        end
    end

    // Counts lookups that overtook a waiting update.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (grant_lk && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) pred_valid_q <= 1'b0;
        else pred_valid_q <= grant_lk;
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = pred_valid_q & tbl_rdata_i[33];
    assign pred_target_o = pred_valid_q ? tbl_rdata_i[31:0] : 32'h0;

    // Port outputs are held quiet for as long as reset is asserted.
    assign tbl_en_o = en & reset_ni;
    assign tbl_we_o = we & reset_ni;
    assign tbl_addr_o = reset_ni ? addr : '0;
    assign tbl_wdata_o = reset_ni ? wdata : '0;

    assign lookup_ready_o = reset_ni && state == IDLE && !force_upd;
    assign upd_ready_o = reset_ni && !full;
    assign clear_busy_o = (state == CLEAR);

endmodule

// File: tb/tb_pht_port_sched.sv
// Directed bench for pht_port_sched with a behavioural single-port table RAM.
// Checks clear, lookup, counter update, starvation and FIFO-full behaviour.
module tb_pht_port_sched;

    logic clk = 1'b0;
    logic reset_ni;
    logic lookup_valid;
    logic [3:0] lookup_idx;
    logic lookup_ready;
    logic pred_valid;
    logic pred_taken;
    logic [31:0] pred_target;
    logic upd_valid;
    logic [3:0] upd_idx;
    logic upd_taken;
    logic [31:0] upd_target;
    logic upd_ready;
    logic clear_busy;
    logic tbl_en;
    logic tbl_we;
    logic [3:0] tbl_addr;
    logic [33:0] tbl_wdata;
    logic [33:0] tbl_rdata;

    logic [33:0] mem [16];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) mem[tbl_addr] <= tbl_wdata;
            else tbl_rdata <= mem[tbl_addr];
        end
    end

    pht_port_sched dut (
        .clk_i(clk),
        .reset_ni(reset_ni),
        .lookup_valid_i(lookup_valid),
        .lookup_idx_i(lookup_idx),
        .lookup_ready_o(lookup_ready),
        .pred_valid_o(pred_valid),
        .pred_taken_o(pred_taken),
        .pred_target_o(pred_target),
        .upd_valid_i(upd_valid),
        .upd_idx_i(upd_idx),
        .upd_taken_i(upd_taken),
        .upd_target_i(upd_target),
        .upd_ready_o(upd_ready),
        .clear_busy_o(clear_busy),
        .tbl_en_o(tbl_en),
        .tbl_we_o(tbl_we),
        .tbl_addr_o(tbl_addr),
        .tbl_wdata_o(tbl_wdata),
        .tbl_rdata_i(tbl_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic run_clear(input int npush);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) reset_ni = 1'b1;
            upd_valid = (i < npush);
            upd_idx = 4'(8 + i);
            upd_taken = 1'b1;
            upd_target = 32'h100 * (i + 1);
            #1;
            chk("clr_en", 64'(tbl_en), 64'd1);
            chk("clr_we", 64'(tbl_we), 64'd1);
            chk("clr_addr", 64'(tbl_addr), 64'(i));
            chk("clr_wdata", 64'(tbl_wdata), {30'd0, 2'b01, 32'h0});
            chk("clr_busy", 64'(clear_busy), 64'd1);
            chk("clr_lk_rdy", 64'(lookup_ready), 64'd0);
            chk("clr_up_rdy", 64'(upd_ready),
                64'((npush < 4) || (i < 4)));
        end
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        chk("clr_done", 64'(clear_busy), 64'd0);
    endtask

    task automatic lookup(input logic [3:0] idx, input logic et,
                          input logic [31:0] etg);
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_idx = idx;
        #1;
        chk("lk_ready", 64'(lookup_ready), 64'd1);
        chk("lk_addr", 64'(tbl_addr), 64'(idx));
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        chk("pred_valid", 64'(pred_valid), 64'd1);
        chk("pred_taken", 64'(pred_taken), 64'(et));
        chk("pred_target", 64'(pred_target), 64'(etg));
    endtask

    task automatic update(input logic [3:0] idx, input logic tk,
                          input logic [31:0] tg, input logic [33:0] ew);
        @(negedge clk);
        upd_valid = 1'b1;
        upd_idx = idx;
        upd_taken = tk;
        upd_target = tg;
        #1;
        chk("up_ready", 64'(upd_ready), 64'd1);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        chk("up_rd_en", 64'(tbl_en), 64'd1);
        chk("up_rd_we", 64'(tbl_we), 64'd0);
        chk("up_rd_addr", 64'(tbl_addr), 64'(idx));
        @(negedge clk);
        #1;
        chk("up_wr_we", 64'(tbl_we), 64'd1);
        chk("up_wr_addr", 64'(tbl_addr), 64'(idx));
        chk("up_wr_data", 64'(tbl_wdata), 64'(ew));
        chk("up_wr_lkrdy", 64'(lookup_ready), 64'd0);
    endtask

    initial begin
        reset_ni = 1'b0;
        lookup_valid = 1'b0;
        lookup_idx = '0;
        upd_valid = 1'b0;
        upd_idx = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        repeat (2) @(negedge clk);
        upd_valid = 1'b1;
        #1;
        chk("rst_en", 64'(tbl_en), 64'd0);
        chk("rst_we", 64'(tbl_we), 64'd0);
        chk("rst_addr", 64'(tbl_addr), 64'd0);
        chk("rst_wdata", 64'(tbl_wdata), 64'd0);
        chk("rst_lkrdy", 64'(lookup_ready), 64'd0);
        chk("rst_uprdy", 64'(upd_ready), 64'd0);
        chk("rst_pvalid", 64'(pred_valid), 64'd0);
        chk("rst_ptgt", 64'(pred_target), 64'd0);
        chk("rst_busy", 64'(clear_busy), 64'd1);
        upd_valid = 1'b0;

        run_clear(0);
        lookup(4'd5, 1'b0, 32'h0);

        update(4'd3, 1'b1, 32'h1000, {2'b10, 32'h1000});
        lookup(4'd3, 1'b1, 32'h1000);
        update(4'd3, 1'b1, 32'h1000, {2'b11, 32'h1000});
        update(4'd3, 1'b1, 32'h1000, {2'b11, 32'h1000});
        update(4'd3, 1'b0, 32'hDEAD, {2'b10, 32'h1000});
        lookup(4'd3, 1'b1, 32'h1000);
        update(4'd7, 1'b0, 32'hBEEF, {2'b00, 32'h0});
        update(4'd7, 1'b0, 32'hBEEF, {2'b00, 32'h0});
        lookup(4'd7, 1'b0, 32'h0);

        // starvation: one update waits behind a stream of lookups
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_idx = 4'd1;
        upd_valid = 1'b1;
        upd_idx = 4'd2;
        upd_taken = 1'b1;
        upd_target = 32'h2000;
        #1;
        chk("st_lk0", 64'(lookup_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            upd_valid = 1'b0;
            #1;
            chk("st_lk_rdy", 64'(lookup_ready), 64'd1);
            chk("st_lk_addr", 64'(tbl_addr), 64'd1);
        end
        @(negedge clk);
        #1;
        chk("st_rd_rdy", 64'(lookup_ready), 64'd0);
        chk("st_rd_we", 64'(tbl_we), 64'd0);
        chk("st_rd_addr", 64'(tbl_addr), 64'd2);
        @(negedge clk);
        #1;
        chk("st_wr_rdy", 64'(lookup_ready), 64'd0);
        chk("st_wr_we", 64'(tbl_we), 64'd1);
        chk("st_wr_data", 64'(tbl_wdata), {30'd0, 2'b10, 32'h2000});
        @(negedge clk);
        #1;
        chk("st_resume", 64'(lookup_ready), 64'd1);
        @(negedge clk);
        lookup_valid = 1'b0;

        // reset in the write cycle of an update, with one entry queued
        upd_valid = 1'b1;
        upd_idx = 4'd12;
        upd_target = 32'hC00;
        @(negedge clk);
        upd_idx = 4'd13;
        upd_target = 32'hD00;
        #1;
        chk("rr_rd_addr", 64'(tbl_addr), 64'd12);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        chk("rr_wr_we", 64'(tbl_we), 64'd1);
        reset_ni = 1'b0;
        #1;
        chk("rr_we_drop", 64'(tbl_we), 64'd0);
        chk("rr_en_drop", 64'(tbl_en), 64'd0);
        chk("rr_busy", 64'(clear_busy), 64'd1);
        run_clear(0);
        chk("rr_fifo_empty", 64'(tbl_en), 64'd0);
        chk("rr_uprdy", 64'(upd_ready), 64'd1);

        // fill the FIFO during a clear, then drain in order
        reset_ni = 1'b0;
        run_clear(4);
        lookup_valid = 1'b1;
        lookup_idx = 4'd0;
        #1;
        chk("fu_lkrdy", 64'(lookup_ready), 64'd0);
        chk("fu_uprdy", 64'(upd_ready), 64'd0);
        chk("fu_rd_addr", 64'(tbl_addr), 64'd8);
        chk("fu_rd_we", 64'(tbl_we), 64'd0);
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        chk("fu_wr_addr", 64'(tbl_addr), 64'd8);
        chk("fu_wr_data", 64'(tbl_wdata), {30'd0, 2'b10, 32'h100});
        chk("fu_uprdy2", 64'(upd_ready), 64'd1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("fu_rd_n", 64'(tbl_addr), 64'(8 + k));
            chk("fu_rd_we_n", 64'(tbl_we), 64'd0);
            @(negedge clk);
            #1;
            chk("fu_wr_n", 64'(tbl_addr), 64'(8 + k));
            chk("fu_wd_n", 64'(tbl_wdata),
                {30'd0, 2'b10, 32'h100 * (k + 1)});
        end
        @(negedge clk);
        #1;
        chk("fu_idle", 64'(tbl_en), 64'd0);
        lookup(4'd11, 1'b1, 32'h400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
